quad_gate_checker: RTL and testbench
====================================

QUAD_GATE_CHECKER -- requirements
Module: quad_gate_checker

Interface
REQ-001 Parameters SHALL be:
  - FUNC, default 3'd5, expected gate function: 0=AND, 1=OR, 2=NAND, 3=NOR, 5=XOR, 6=XNOR.
  - SETTLE_CYC, default 2, clock cycles allowed for DUT outputs to settle; legal range 1..15.
REQ-002 Ports SHALL be:
  - Clk  in  1  single system clock, rising edge.
  - Rst_n  in  1  asynchronous active-low reset.
  - Start  in  1  run request, sampled only in IDLE.
  - A1,B1,A2,B2,A3,B3,A4,B4  out  1 each  stimulus driven to the quad 2-input gate under test.
  - Y1,Y2,Y3,Y4  in  1 each  gate outputs returned from the part under test.
  - Busy  out  1  run in progress.
  - Done  out  1  one-cycle pulse at run end.
  - Pass  out  1  last run had zero mismatches.
  - FailMask  out  4  bit g-1 set if gate g mismatched at least once.
  - ErrCount  out  5  number of vectors (0..16) with any mismatch.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 States SHALL be IDLE, SETTLE, CHECK, FINISH.
REQ-005 IDLE with Start=1 SHALL clear FailMask/ErrCount/Pass, set Busy, load vector index 0, and enter SETTLE; Start in any other state SHALL be ignored.
REQ-006 Vector sequence SHALL be gate 1..4 in order, per gate (A,B)=00,01,10,11; idle gates SHALL be held at A=B=0; 16 vectors total.
REQ-007 Stimulus outputs SHALL be registered and update on the edge entering SETTLE.
REQ-008 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter CHECK.
REQ-009 CHECK SHALL last one cycle and compare all four Y against FUNC(A,B) of each gate's current inputs.
  - Mismatch on gate g SHALL set FailMask[g-1].
  - Any mismatch in the vector SHALL increment ErrCount once.
  - Result registers SHALL update on the edge leaving CHECK.
REQ-010 From CHECK, vector index <15 SHALL increment and return to SETTLE; index 15 SHALL enter FINISH.
REQ-011 FINISH SHALL last one cycle:
  - Done=1, Pass=(ErrCount==0), all stimulus driven 0.
  - Next state IDLE with Busy=0.
REQ-012 Done SHALL assert exactly 16*(SETTLE_CYC+1)+1 cycles after the Start-accept edge.
REQ-013 Results SHALL hold until next accepted Start or reset.
REQ-014 Y inputs are same-clock-domain combinational returns; no synchronizer SHALL be inserted.
REQ-015 ErrCount SHALL saturate at 16 (no wrap); the 5-bit width covers this.
REQ-016 Unsupported FUNC codes (4, 7) SHALL be treated as XOR.

Reset
REQ-017 Rst_n low SHALL force, asynchronously:
  - State IDLE.
  - All stimulus outputs 0.
  - Busy=0, Done=0, Pass=0, FailMask=0, ErrCount=0.
  - Counters 0.
REQ-018 Reset mid-run SHALL abort with no Done pulse; a run SHALL start only on Start after Rst_n deasserts.

Structure
REQ-019 A shared package SHALL hold:
  - The state enum.
  - FUNC code constants.
  - A function returning expected output for (FUNC, A, B).
REQ-020 One sub-module, quad_gate_checker_seq (state machine plus settle/vector counters), is natural; compare/accumulate logic SHALL stay in the top.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - XOR DUT, Delay 0, FUNC=5, SETTLE_CYC=2, Start pulse -> Done at cycle 49 after accept; Pass=1, FailMask=0000, ErrCount=0.
  - As above with Y3 forced 0 -> Pass=0, FailMask=0100, ErrCount=2 (gate-3 vectors 01,10).
  - XOR DUT with FUNC=2 (NAND) -> every vector has an idle gate at 00 mismatching; FailMask=1111, ErrCount=16.
  - Second Start pulse 5 cycles into run -> ignored; exactly one Done; counts unchanged from the first scenario.
  - Rst_n low at cycle 10 of a run -> stimulus all 0, Busy=0 immediately; no Done; new Start then completes with Pass=1.
  - SETTLE_CYC=1 -> Done at cycle 33; A1/B1 sequence 00,01,10,11 observed with 2-cycle spacing.

Source files
------------

// File: rtl/quad_gate_checker_pkg.sv
// Shared types, function codes and the reference gate function for the quad gate checker.
package quad_gate_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_FINISH = 2'd3
    } qgc_state_e;

    localparam logic [2:0] FN_AND  = 3'd0;
    localparam logic [2:0] FN_OR   = 3'd1;
    localparam logic [2:0] FN_NAND = 3'd2;
    localparam logic [2:0] FN_NOR  = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd5;
    localparam logic [2:0] FN_XNOR = 3'd6;

    localparam int unsigned NUM_GATES = 4;
    localparam int unsigned VEC_W     = 4;
    localparam int unsigned ERR_W     = 5;
    localparam int unsigned CNT_W     = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = 4'd15;
    localparam logic [ERR_W-1:0] ERR_MAX  = 5'd16;

    // Expected gate output; codes 4 and 7 fall back to XOR.
    function automatic logic gate_expect(input logic [2:0] func, input logic a, input logic b);
        logic y;
        case (func)
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_NAND: y = ~(a & b);
            FN_NOR:  y = ~(a | b);
            FN_XNOR: y = ~(a ^ b);
            default: y = a ^ b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/quad_gate_checker_seq.sv
// Run sequencer: IDLE/SETTLE/CHECK/FINISH state machine with settle and vector counters.
module quad_gate_checker_seq
    import quad_gate_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_start,
    output logic [1:0]       o_state,
    output logic             o_accept_c,
    output logic             o_enter_settle_c,
    output logic             o_enter_finish_c,
    output logic [VEC_W-1:0] o_next_idx_c
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    qgc_state_e       r_state;
    qgc_state_e       w_next_state;
    logic [VEC_W-1:0] r_vec_idx;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             w_settle_done;

    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
    assign o_state       = r_state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        o_accept_c       = 1'b0;
        o_enter_settle_c = 1'b0;
        o_enter_finish_c = 1'b0;
        o_next_idx_c     = r_vec_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state     = S_SETTLE;
                    o_accept_c       = 1'b1;
                    o_enter_settle_c = 1'b1;
                    o_next_idx_c     = '0;
                end
            end
            S_SETTLE: begin
                if (w_settle_done) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_vec_idx == LAST_VEC) begin
                    w_next_state     = S_FINISH;
                    o_enter_finish_c = 1'b1;
                end else begin
                    w_next_state     = S_SETTLE;
                    o_enter_settle_c = 1'b1;
                    o_next_idx_c     = r_vec_idx + VEC_W'(1);
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Settle counter restarts at zero on every entry into SETTLE.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_vec_idx    <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_vec_idx <= o_next_idx_c;
            if ((r_state == S_SETTLE) && !w_settle_done) begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_gate_checker.sv
// Quad 2-input gate checker: walks 16 stimulus vectors, compares returned outputs and accumulates results.
module quad_gate_checker
    import quad_gate_checker_pkg::*;
#(
    parameter logic [2:0]  FUNC       = 3'd5,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    output logic       A1,
    output logic       B1,
    output logic       A2,
    output logic       B2,
    output logic       A3,
    output logic       B3,
    output logic       A4,
    output logic       B4,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       Y3,
    input  logic       Y4,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [3:0] FailMask,
    output logic [4:0] ErrCount
);

    logic [1:0]           w_state;
    logic                 w_accept;
    logic                 w_enter_settle;
    logic                 w_enter_finish;
    logic [VEC_W-1:0]     w_next_idx;
    logic [NUM_GATES-1:0] r_a;
    logic [NUM_GATES-1:0] r_b;
    logic [NUM_GATES-1:0] w_a_nxt;
    logic [NUM_GATES-1:0] w_b_nxt;
    logic [NUM_GATES-1:0] w_y;
    logic [NUM_GATES-1:0] w_exp;
    logic [NUM_GATES-1:0] w_mism;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [NUM_GATES-1:0] r_fail_mask;
    logic [ERR_W-1:0]     r_err_count;

    quad_gate_checker_seq #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_seq (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .i_start          (Start),
        .o_state          (w_state),
        .o_accept_c       (w_accept),
        .o_enter_settle_c (w_enter_settle),
        .o_enter_finish_c (w_enter_finish),
        .o_next_idx_c     (w_next_idx)
    );

    // Vector index: upper bits pick the active gate, lower bits are (A,B); idle gates stay at 00.
    always_comb begin
        w_a_nxt = '0;
        w_b_nxt = '0;
        w_a_nxt[w_next_idx[3:2]] = w_next_idx[1];
        w_b_nxt[w_next_idx[3:2]] = w_next_idx[0];
    end

    always_comb begin
        w_exp = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            w_exp[g] = gate_expect(FUNC, r_a[g], r_b[g]);
        end
    end

    assign w_y    = {Y4, Y3, Y2, Y1};
    assign w_mism = w_y ^ w_exp;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_enter_settle) begin
            r_a <= w_a_nxt;
            r_b <= w_b_nxt;
        end else if (w_enter_finish) begin
            r_a <= '0;
            r_b <= '0;
        end
    end

    // Results accumulate on each CHECK exit and are published on the FINISH exit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_count <= '0;
        end else begin
            r_done <= (w_state == S_FINISH);
            if (w_accept) begin
                r_busy      <= 1'b1;
                r_pass      <= 1'b0;
                r_fail_mask <= '0;
                r_err_count <= '0;
            end else if (w_state == S_CHECK) begin
                r_fail_mask <= r_fail_mask | w_mism;
                if ((|w_mism) && (r_err_count != ERR_MAX)) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
            end else if (w_state == S_FINISH) begin
                r_pass <= (r_err_count == '0);
                r_busy <= 1'b0;
            end
        end
    end

    assign A1       = r_a[0];
    assign B1       = r_b[0];
    assign A2       = r_a[1];
    assign B2       = r_b[1];
    assign A3       = r_a[2];
    assign B3       = r_b[2];
    assign A4       = r_a[3];
    assign B4       = r_b[3];
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Pass     = r_pass;
    assign FailMask = r_fail_mask;
    assign ErrCount = r_err_count;

endmodule

// File: tb/tb_quad_gate_checker.sv
// Bench for quad_gate_checker: nine checkers (FUNC 0..7 at SETTLE_CYC=2, XOR at SETTLE_CYC=1) driving table-modelled gate parts.
module tb_quad_gate_checker;

    localparam int NK     = 9;
    localparam int E_LAST = 55;

    logic clk;
    logic rst_n;
    logic start;

    logic [NK-1:0][3:0] w_a;
    logic [NK-1:0][3:0] w_b;
    logic [NK-1:0][3:0] w_y;
    logic [NK-1:0]      w_busy;
    logic [NK-1:0]      w_done;
    logic [NK-1:0]      w_pass;
    logic [NK-1:0][3:0] w_mask;
    logic [NK-1:0][4:0] w_err;

    // Truth table of each gate of each part: tt[k][g][{a,b}].
    logic [3:0] tt [NK][4];

    int n_vec;
    int n_err;
    int last_done_edge [NK];
    int last_done_cnt  [NK];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        quad_gate_checker #(
            .FUNC       (3'(k < 8 ? k : 5)),
            .SETTLE_CYC (k < 8 ? 2 : 1)
        ) u_dut (
            .Clk      (clk),
            .Rst_n    (rst_n),
            .Start    (start),
            .A1       (w_a[k][0]),
            .B1       (w_b[k][0]),
            .A2       (w_a[k][1]),
            .B2       (w_b[k][1]),
            .A3       (w_a[k][2]),
            .B3       (w_b[k][2]),
            .A4       (w_a[k][3]),
            .B4       (w_b[k][3]),
            .Y1       (w_y[k][0]),
            .Y2       (w_y[k][1]),
            .Y3       (w_y[k][2]),
            .Y4       (w_y[k][3]),
            .Busy     (w_busy[k]),
            .Done     (w_done[k]),
            .Pass     (w_pass[k]),
            .FailMask (w_mask[k]),
            .ErrCount (w_err[k])
        );
        for (genvar g = 0; g < 4; g++) begin : g_part
            assign w_y[k][g] = tt[k][g][{w_a[k][g], w_b[k][g]}];
        end
    end

    function automatic int func_of(input int k);
        return (k < 8) ? k : 5;
    endfunction

    function automatic int settle_of(input int k);
        return (k < 8) ? 2 : 1;
    endfunction

    // Gate function from the count of ones on the inputs; unsupported codes behave as XOR.
    function automatic bit ref_fn(input int f, input int a, input int b);
        int s;
        s = a + b;
        case (f)
            0:       return s == 2;
            1:       return s >= 1;
            2:       return s != 2;
            3:       return s == 0;
            6:       return s != 1;
            default: return s == 1;
        endcase
    endfunction

    function automatic logic [3:0] good_table(input int f);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) t[i] = ref_fn(f, i / 2, i % 2);
        return t;
    endfunction

    // Run-level reference: walk the 16 vectors and score the part's tables.
    task automatic model(input int k, output logic [3:0] m, output logic [4:0] ec);
        int cnt;
        m   = '0;
        cnt = 0;
        for (int v = 0; v < 16; v++) begin
            bit any;
            any = 1'b0;
            for (int g = 0; g < 4; g++) begin
                int a;
                int b;
                logic [3:0] t;
                a = (g == v / 4) ? (v % 4) / 2 : 0;
                b = (g == v / 4) ? v % 2 : 0;
                t = tt[k][g];
                if (t[a * 2 + b] != ref_fn(func_of(k), a, b)) begin
                    m[g] = 1'b1;
                    any  = 1'b1;
                end
            end
            if (any) cnt++;
        end
        ec = 5'(cnt);
    endtask

    task automatic set_all_xor();
        for (int k = 0; k < NK; k++)
            for (int g = 0; g < 4; g++) tt[k][g] = 4'b0110;
    endtask

    // One run on all checkers; per-edge stimulus/Busy/Done checks, then result checks.
    task automatic run_check(input string tag, input int abort_at, input int restart_at);
        for (int k = 0; k < NK; k++) begin
            last_done_edge[k] = -1;
            last_done_cnt[k]  = 0;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 0; e <= E_LAST; e++) begin
            bit ab;
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (e == restart_at) start = 1'b1;
            if (e == restart_at + 1) start = 1'b0;
            if (e == abort_at) begin
                rst_n = 1'b0;
                #1;
            end
            ab = (abort_at >= 0) && (e >= abort_at);
            for (int k = 0; k < NK; k++) begin
                int per;
                int v;
                logic [3:0] ea;
                logic [3:0] eb;
                logic eb_busy;
                logic e_done;
                per = settle_of(k) + 1;
                ea = '0;
                eb = '0;
                eb_busy = 1'b0;
                e_done = 1'b0;
                if (!ab) begin
                    if (e < 16 * per) begin
                        v = e / per;
                        ea[v / 4] = 1'((v % 4) / 2);
                        eb[v / 4] = 1'(v % 2);
                    end
                    eb_busy = (e < 16 * per + 1);
                    e_done  = (e == 16 * per + 1);
                end
                if (w_done[k] === 1'b1) begin
                    last_done_cnt[k]++;
                    if (last_done_edge[k] < 0) last_done_edge[k] = e;
                end
                n_vec++;
                if ({w_a[k], w_b[k]} !== {ea, eb}) begin
                    n_err++;
                    $display("FAIL %s stim k=%0d e=%0d got A=%b B=%b exp A=%b B=%b",
                             tag, k, e, w_a[k], w_b[k], ea, eb);
                end
                n_vec++;
                if (w_busy[k] !== eb_busy) begin
                    n_err++;
                    $display("FAIL %s busy k=%0d e=%0d got=%b exp=%b", tag, k, e, w_busy[k], eb_busy);
                end
                n_vec++;
                if (w_done[k] !== e_done) begin
                    n_err++;
                    $display("FAIL %s done k=%0d e=%0d got=%b exp=%b", tag, k, e, w_done[k], e_done);
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            logic [3:0] m;
            logic [4:0] ec;
            logic       ep;
            if (abort_at >= 0) begin
                m  = '0;
                ec = '0;
                ep = 1'b0;
            end else begin
                model(k, m, ec);
                ep = (ec == 5'd0);
            end
            n_vec++;
            if ({w_pass[k], w_mask[k], w_err[k]} !== {ep, m, ec}) begin
                n_err++;
                $display("FAIL %s result k=%0d got pass=%b mask=%b err=%0d exp pass=%b mask=%b err=%0d",
                         tag, k, w_pass[k], w_mask[k], w_err[k], ep, m, ec);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        set_all_xor();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            n_vec++;
            if ({w_a[k], w_b[k], w_busy[k], w_done[k], w_pass[k], w_mask[k], w_err[k]} !== 20'd0) begin
                n_err++;
                $display("FAIL reset k=%0d got A=%b B=%b busy=%b done=%b pass=%b mask=%b err=%0d", k,
                         w_a[k], w_b[k], w_busy[k], w_done[k], w_pass[k], w_mask[k], w_err[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_xor_pass();
        set_all_xor();
        run_check("xor_pass", -1, -1);
        n_vec++;
        if (last_done_edge[5] != 49 || w_pass[5] !== 1'b1 || w_mask[5] !== 4'b0000 || w_err[5] !== 5'd0) begin
            n_err++;
            $display("FAIL xor_pass_direct got done_edge=%0d pass=%b mask=%b err=%0d exp 49 1 0000 0",
                     last_done_edge[5], w_pass[5], w_mask[5], w_err[5]);
        end
    endtask

    task automatic test_stuck_y3();
        set_all_xor();
        tt[5][2] = 4'b0000;
        run_check("stuck_y3", -1, -1);
        n_vec++;
        if (w_pass[5] !== 1'b0 || w_mask[5] !== 4'b0100 || w_err[5] !== 5'd2) begin
            n_err++;
            $display("FAIL stuck_y3_direct got pass=%b mask=%b err=%0d exp 0 0100 2",
                     w_pass[5], w_mask[5], w_err[5]);
        end
    endtask

    task automatic test_nand_func();
        set_all_xor();
        run_check("nand_func", -1, -1);
        n_vec++;
        if (w_pass[2] !== 1'b0 || w_mask[2] !== 4'b1111 || w_err[2] !== 5'd16) begin
            n_err++;
            $display("FAIL nand_func_direct got pass=%b mask=%b err=%0d exp 0 1111 16",
                     w_pass[2], w_mask[2], w_err[2]);
        end
    endtask

    task automatic test_ignored_start();
        set_all_xor();
        run_check("ignored_start", -1, 5);
        n_vec++;
        if (last_done_cnt[5] != 1 || w_pass[5] !== 1'b1 || w_mask[5] !== 4'b0000 || w_err[5] !== 5'd0) begin
            n_err++;
            $display("FAIL ignored_start_direct got done_cnt=%0d pass=%b mask=%b err=%0d exp 1 1 0000 0",
                     last_done_cnt[5], w_pass[5], w_mask[5], w_err[5]);
        end
    endtask

    task automatic test_reset_midrun();
        set_all_xor();
        run_check("reset_midrun", 10, -1);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_reset", -1, -1);
        n_vec++;
        if (w_pass[5] !== 1'b1 || last_done_cnt[5] != 1) begin
            n_err++;
            $display("FAIL after_reset_direct got pass=%b done_cnt=%0d exp 1 1", w_pass[5], last_done_cnt[5]);
        end
    endtask

    task automatic test_settle1();
        set_all_xor();
        run_check("settle1", -1, -1);
        n_vec++;
        if (last_done_edge[8] != 33 || w_pass[8] !== 1'b1) begin
            n_err++;
            $display("FAIL settle1_direct got done_edge=%0d pass=%b exp 33 1", last_done_edge[8], w_pass[8]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NK; k++)
                for (int g = 0; g < 4; g++)
                    tt[k][g] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                                           : good_table(func_of(k));
            run_check("random", -1, -1);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_xor_pass();
        test_stuck_y3();
        test_nand_func();
        test_ignored_start();
        test_reset_midrun();
        test_settle1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
